instruction_memory_loader: RTL and testbench

Byte-addressed, big-endian instruction memory that the CPU fetch stage reads and the debug/UART unit loads at run time.
- Replaces the fixed, initial-block program image with a byte-stream loader FSM, using a valid/ready handshake.
- Stops loading on a parametrised HALT word or when memory is full.
- Read port is registered, with alignment and range checking; bad fetches return a NOP.
- Sits between the debug unit (load side) and the IF stage (fetch side).

---
 rtl/instruction_memory_loader.sv | 133 +++++++++++++
 tb/tb_instruction_memory_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// Byte-addressed, big-endian instruction memory.
// The debug unit streams a program in one byte at a time over a valid/ready
// link, and the IF stage reads aligned 32-bit words with a registered read.
// Handshake: a byte transfers on a rising edge where i_byte_valid and
// o_byte_ready are both high. o_byte_ready is registered and is high only
// while loading. The source may hold valid high, and one byte is consumed
// per cycle.
module instruction_memory_loader #(
  parameter int                    NBITS     = 8,
  parameter int                    INST_BITS = 32,
  parameter int                    CELLS     = 256,
  parameter logic [INST_BITS-1:0]  HALT_WORD = 32'hFFFFFFFF,
  parameter int                    CNT_BITS  = $clog2(CELLS) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load_start,
  input  logic                 i_byte_valid,
  input  logic [NBITS-1:0]     i_byte,
  output logic                 o_byte_ready,
  output logic                 o_load_done,
  output logic [CNT_BITS-1:0]  o_load_count,
  input  logic                 i_rd_en,
  input  logic [INST_BITS-1:0] i_addr,
  output logic [INST_BITS-1:0] o_data,
  output logic                 o_addr_err,
  output logic [1:0]           o_dbg_state
);

  localparam int AW = $clog2(CELLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  // The byte counter doubles as the write pointer: both clear and advance together.
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   ready_q;
  logic [INST_BITS-1:0]   data_q, data_d;
  logic                   err_q, err_d;
  logic [NBITS-1:0]       mem [CELLS];

  logic                   accept;
  logic                   halt_hit;
  logic                   full_hit;
  logic                   addr_ok;
  logic [AW-1:0]          wr_idx;
  logic [AW-1:0]          rd_idx;
  logic [INST_BITS-1:0]   asm_word;
  logic [INST_BITS-1:0]   rd_word;

  // Load-side datapath: accepted byte, the word it would complete, and the stop conditions.
  always_comb begin
    wr_idx   = cnt_q[AW-1:0];
    // A byte presented on the edge that resets is dropped rather than written.
    accept   = i_byte_valid & ready_q & ~i_reset;
    asm_word = {mem[wr_idx - AW'(3)], mem[wr_idx - AW'(2)], mem[wr_idx - AW'(1)], i_byte};
    halt_hit = (cnt_q[1:0] == 2'd3) && (asm_word == HALT_WORD);
    full_hit = (wr_idx == AW'(CELLS - 1));
  end

  // Next-state logic for the loader FSM and its byte counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          if (halt_hit || full_hit) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch path: aligned in-range reads return the big-endian word, anything else a NOP.
  always_comb begin
    rd_idx  = i_addr[AW-1:0];
    addr_ok = (i_addr[1:0] == 2'b00) && (i_addr <= INST_BITS'(CELLS - 4));
    rd_word = {mem[rd_idx], mem[rd_idx + AW'(1)], mem[rd_idx + AW'(2)], mem[rd_idx + AW'(3)]};
    data_d  = data_q;
    err_d   = 1'b0;
    // The CPU is stalled during a load, so fetches there are ignored.
    if (i_rd_en && (state_q != S_LOAD)) begin
      if (addr_ok) begin
        data_d = rd_word;
      end else begin
        data_d = '0;
        err_d  = 1'b1;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == S_LOAD);
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Memory array: written only by accepted load bytes, contents survive reset.
  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_idx] <= i_byte;
  end

  assign o_byte_ready = ready_q;
  assign o_load_done  = (state_q == S_DONE);
  assign o_load_count = cnt_q;
  assign o_data       = data_q;
  assign o_addr_err   = err_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: directed load/fetch scenarios, a
// table of fetch vectors, and randomized loads and fetches checked against
// a byte-array model of the memory.
module tb_instruction_memory_loader;

  localparam int CELLS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        load_done;
  logic [8:0]  load_count;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] data;
  logic        addr_err;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: plain byte array plus load progress.
  logic [7:0]  mdl_mem [CELLS];
  int          mdl_cnt = 0;
  bit          mdl_done = 0;
  logic [7:0]  tx_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } fetch_vec_t;

  fetch_vec_t vecs [9];

  instruction_memory_loader dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_load_start (load_start),
    .i_byte_valid (byte_valid),
    .i_byte       (byte_in),
    .o_byte_ready (byte_ready),
    .o_load_done  (load_done),
    .o_load_count (load_count),
    .i_rd_en      (rd_en),
    .i_addr       (addr),
    .o_data       (data),
    .o_addr_err   (addr_err),
    .o_dbg_state  (dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: a byte lands at the next free cell; a load ends when a completed
  // aligned word equals the HALT word or the last cell has been written.
  task automatic mdl_accept(input logic [7:0] b);
    logic [31:0] w;
    mdl_mem[mdl_cnt] = b;
    mdl_cnt++;
    if (mdl_cnt % 4 == 0) begin
      w = {mdl_mem[mdl_cnt-4], mdl_mem[mdl_cnt-3], mdl_mem[mdl_cnt-2], mdl_mem[mdl_cnt-1]};
      if (w == 32'hFFFFFFFF) mdl_done = 1;
    end
    if (mdl_cnt == CELLS) mdl_done = 1;
  endtask

  task automatic mdl_fetch(input logic [31:0] a, output logic [31:0] d, output logic e);
    if (a % 4 == 0 && a <= CELLS - 4) begin
      d = {mdl_mem[a], mdl_mem[a+1], mdl_mem[a+2], mdl_mem[a+3]};
      e = 1'b0;
    end else begin
      d = 32'h0;
      e = 1'b1;
    end
  endtask

  // Driver tasks
  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    mdl_cnt  = 0;
    mdl_done = 0;
  endtask

  // Streams tx_q; gap_pct is the chance of an idle cycle before each byte.
  task automatic drive_bytes(input int gap_pct, output int cycles);
    bit acc;
    cycles = 0;
    while (tx_q.size() > 0 && cycles < 4000) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        byte_valid = 1'b0;
        step();
      end else begin
        byte_valid = 1'b1;
        byte_in    = tx_q[0];
        acc        = byte_ready;
        step();
        if (acc) mdl_accept(tx_q.pop_front());
      end
      cycles++;
    end
    byte_valid = 1'b0;
    if (tx_q.size() != 0) begin
      chk("load_timeout_bytes_left", 32'(tx_q.size()), 32'd0);
      tx_q.delete();
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output logic e);
    rd_en = 1'b1;
    addr  = a;
    step();
    d = data;
    e = addr_err;
    rd_en = 1'b0;
  endtask

  task automatic fetch_vs_model(input string name, input logic [31:0] a);
    logic [31:0] d, ed;
    logic        e, ee;
    mdl_fetch(a, ed, ee);
    do_fetch(a, d, e);
    chk({name, "_data"}, d, ed);
    chk({name, "_err"}, {31'b0, e}, {31'b0, ee});
  endtask

  initial begin
    logic [31:0] d, prev;
    logic        e;
    int          cyc;

    vecs[0] = '{32'd0,         32'h3C0A0002, 1'b0};
    vecs[1] = '{32'd4,         32'h3C0A0003, 1'b0};
    vecs[2] = '{32'd8,         32'hFFFFFFFF, 1'b0};
    vecs[3] = '{32'd2,         32'h0,        1'b1};
    vecs[4] = '{32'd256,       32'h0,        1'b1};
    vecs[5] = '{32'd1,         32'h0,        1'b1};
    vecs[6] = '{32'd3,         32'h0,        1'b1};
    vecs[7] = '{32'h80000000,  32'h0,        1'b1};
    vecs[8] = '{32'h00000104,  32'h0,        1'b1};

    rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h0;
    rd_en = 1'b0; addr = 32'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_done",  {31'b0, load_done},  32'd0);
    chk("rst_count", {23'b0, load_count}, 32'd0);
    chk("rst_data",  data, 32'd0);
    chk("rst_err",   {31'b0, addr_err},   32'd0);

    // Scenario 1: 12-byte program with HALT, valid held high.
    pulse_start();
    chk("s1_ready_after_start", {31'b0, byte_ready}, 32'd1);
    tx_q = '{8'h3C, 8'h0A, 8'h00, 8'h02, 8'h3C, 8'h0A, 8'h00, 8'h03,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    drive_bytes(0, cyc);
    chk("s1_cycles", 32'(cyc), 32'd12);
    chk("s1_done",   {31'b0, load_done},  {31'b0, mdl_done});
    chk("s1_count",  {23'b0, load_count}, 32'd12);
    chk("s1_ready",  {31'b0, byte_ready}, 32'd0);

    // Scenarios 2/3: table of fetch vectors, each followed by an idle cycle.
    foreach (vecs[i]) begin
      do_fetch(vecs[i].addr, d, e);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      addr = 32'h2;
      step();
      chk($sformatf("vec%0d_err_clears", i), {31'b0, addr_err}, 32'd0);
      chk($sformatf("vec%0d_hold", i), data, d);
    end

    // Scenario 6: restart from DONE, start pulse and fetch ignored in LOAD.
    pulse_start();
    tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    drive_bytes(0, cyc);
    prev = data;
    load_start = 1'b1; rd_en = 1'b1; addr = 32'h2;
    step();
    load_start = 1'b0; rd_en = 1'b0;
    chk("s6_start_in_load_count", {23'b0, load_count}, 32'd4);
    chk("s6_start_in_load_ready", {31'b0, byte_ready}, 32'd1);
    chk("s6_fetch_in_load_err",   {31'b0, addr_err},   32'd0);
    chk("s6_fetch_in_load_data",  data, prev);
    tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    drive_bytes(0, cyc);
    chk("s6_done",  {31'b0, load_done},  32'd1);
    chk("s6_count", {23'b0, load_count}, 32'd8);
    do_fetch(32'd0, d, e);
    chk("s6_fetch0", d, 32'hAABBCCDD);
    fetch_vs_model("s6_fetch4", 32'd4);

    // Last byte of a load and a bad fetch on the same edge: fetch ignored.
    pulse_start();
    tx_q = '{8'hFF, 8'hFF, 8'hFF};
    drive_bytes(0, cyc);
    prev = data;
    byte_valid = 1'b1; byte_in = 8'hFF; rd_en = 1'b1; addr = 32'h1;
    step();
    byte_valid = 1'b0; rd_en = 1'b0;
    mdl_accept(8'hFF);
    chk("edge_done", {31'b0, load_done}, {31'b0, mdl_done});
    chk("edge_err",  {31'b0, addr_err},  32'd0);
    chk("edge_data", data, prev);

    // Scenario 4: 256 random bytes with gaps, no HALT word possible (no FF).
    pulse_start();
    for (int i = 0; i < CELLS; i++) tx_q.push_back(8'($urandom_range(0, 254)));
    drive_bytes(30, cyc);
    chk("s4_done",  {31'b0, load_done},  {31'b0, mdl_done});
    chk("s4_count", {23'b0, load_count}, 32'd256);
    chk("s4_ready", {31'b0, byte_ready}, 32'd0);
    byte_valid = 1'b1; byte_in = ~mdl_mem[0];
    step();
    byte_valid = 1'b0;
    chk("s4_257th_count", {23'b0, load_count}, 32'd256);
    fetch_vs_model("s4_257th_mem0", 32'd0);
    fetch_vs_model("s4_fetch252", 32'd252);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) fetch_vs_model($sformatf("rnd%0d", i), 32'($urandom_range(0, 63) * 4));
      else fetch_vs_model($sformatf("rnd%0d", i), $urandom_range(0, 300));
    end

    // Scenario 5: reset after 5 bytes keeps memory, clears the count.
    pulse_start();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_bytes(0, cyc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl_cnt = 0;
    chk("s5_count", {23'b0, load_count}, 32'd0);
    chk("s5_ready", {31'b0, byte_ready}, 32'd0);
    chk("s5_done",  {31'b0, load_done},  32'd0);
    do_fetch(32'd0, d, e);
    chk("s5_fetch0", d, 32'h11223344);
    fetch_vs_model("s5_fetch4", 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
